// File: rtl/fir_coef_mac.sv
// Serial 5-tap style FIR: one sample in, one coefficient fetched and multiplied per cycle.
// Optional macro FIR_ROUND_EN selects round-half-up instead of truncation on the output scale.
module fir_coef_mac #(
  parameter int unsigned NrOfWords = 5,
  parameter int unsigned WordSize  = 12,
  parameter int unsigned AddrsSize = 3,
  parameter int unsigned AccSize   = 2 * WordSize + 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sampleValid,
  input  logic [WordSize-1:0]  sampleIn,
  output logic                 read,
  output logic [AddrsSize-1:0] addrs,
  input  logic [WordSize-1:0]  romData,
  output logic                 busy,
  output logic [WordSize-1:0]  result,
  output logic                 resultValid
);

  localparam int unsigned ProdSize = 2 * WordSize;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                       state_q, state_d;
  logic signed [WordSize-1:0]   tap_q [NrOfWords];
  logic signed [WordSize-1:0]   tap_d [NrOfWords];
  logic signed [AccSize-1:0]    acc_q, acc_d;
  logic        [AddrsSize-1:0]  k_q, k_d;
  logic        [AddrsSize-1:0]  kprev_q, kprev_d;
  logic                         rd_prev_q, rd_prev_d;
  logic                         read_q, read_d;
  logic        [AddrsSize-1:0]  addrs_q, addrs_d;
  logic                         busy_q, busy_d;
  logic        [WordSize-1:0]   result_q, result_d;
  logic                         result_valid_q, result_valid_d;

  logic signed [ProdSize-1:0]   prod_c;
  logic signed [AccSize-1:0]    acc_fin_c;

  // Coefficient returned this cycle pairs with the tap addressed on the previous cycle.
  assign prod_c = $signed(romData) * tap_q[kprev_q];

  always_comb begin
    state_d        = state_q;
    tap_d          = tap_q;
    acc_d          = acc_q;
    k_d            = k_q;
    kprev_d        = addrs_q;
    rd_prev_d      = read_q;
    read_d         = 1'b0;
    addrs_d        = '0;
    result_d       = result_q;
    result_valid_d = 1'b0;

    if (rd_prev_q) begin
      acc_d = acc_q + AccSize'(prod_c);
    end

`ifdef FIR_ROUND_EN
    acc_fin_c = acc_d + (AccSize'(1) << (WordSize - 2));
`else
    acc_fin_c = acc_d;
`endif

    case (state_q)
      S_IDLE: begin
        if (sampleValid) begin
          for (int i = NrOfWords - 1; i > 0; i--) begin
            tap_d[i] = tap_q[i-1];
          end
          tap_d[0] = $signed(sampleIn);
          acc_d    = '0;
          k_d      = '0;
          read_d   = 1'b1;
          addrs_d  = '0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        if (k_q == AddrsSize'(NrOfWords - 1)) begin
          state_d = S_DRAIN;
        end else begin
          k_d     = k_q + AddrsSize'(1);
          read_d  = 1'b1;
          addrs_d = k_d;
        end
      end
      S_DRAIN: begin
        // Last product lands on this edge, so the result is scaled from the updated sum.
        result_d       = WordSize'(acc_fin_c >>> (WordSize - 1));
        result_valid_d = 1'b1;
        state_d        = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      for (int i = 0; i < NrOfWords; i++) begin
        tap_q[i] <= '0;
      end
      acc_q          <= '0;
      k_q            <= '0;
      kprev_q        <= '0;
      rd_prev_q      <= 1'b0;
      read_q         <= 1'b0;
      addrs_q        <= '0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      tap_q          <= tap_d;
      acc_q          <= acc_d;
      k_q            <= k_d;
      kprev_q        <= kprev_d;
      rd_prev_q      <= rd_prev_d;
      read_q         <= read_d;
      addrs_q        <= addrs_d;
      busy_q         <= busy_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign read        = read_q;
  assign addrs       = addrs_q;
  assign busy        = busy_q;
  assign result      = result_q;
  assign resultValid = result_valid_q;

endmodule

// File: tb/tb_fir_coef_mac.sv
// Directed bench for fir_coef_mac: coefficient store model, vector table, reset-abort sequence.
module tb_fir_coef_mac;

  logic        clk = 1'b0;
  logic        reset;
  logic        sampleValid;
  logic [11:0] sampleIn;
  logic        read;
  logic [2:0]  addrs;
  logic [11:0] romData;
  logic        busy;
  logic [11:0] result;
  logic        resultValid;

  int errors = 0;
  int checks = 0;

  logic [11:0] coef [5];

  typedef struct {
    logic [11:0] sample;
    bit          pulse;
    logic [11:0] exp_trunc;
    logic [11:0] exp_round;
  } vec_t;

  vec_t vecs [7];

  fir_coef_mac dut (
    .clk        (clk),
    .reset      (reset),
    .sampleValid(sampleValid),
    .sampleIn   (sampleIn),
    .read       (read),
    .addrs      (addrs),
    .romData    (romData),
    .busy       (busy),
    .result     (result),
    .resultValid(resultValid)
  );

  always #5 clk = ~clk;

  // Coefficient store: data one cycle after read, junk otherwise.
  always @(posedge clk) begin
    if (read) romData <= coef[addrs];
    else      romData <= 12'h5A5;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sample(input logic [11:0] s, input bit pulse, input logic [11:0] exp);
    sampleValid = 1'b1;
    sampleIn    = s;
    tick();
    sampleValid = 1'b0;
    sampleIn    = 12'h000;
    for (int i = 0; i < 5; i++) begin
      chk("read_fetch", 32'(read), 32'd1);
      chk("addrs_fetch", 32'(addrs), 32'(i));
      chk("busy_fetch", 32'(busy), 32'd1);
      chk("rv_fetch", 32'(resultValid), 32'd0);
      if (pulse && i == 2) begin
        sampleValid = 1'b1;
        sampleIn    = 12'h7FF;
      end else begin
        sampleValid = 1'b0;
      end
      tick();
    end
    sampleValid = 1'b0;
    chk("read_drain", 32'(read), 32'd0);
    chk("addrs_drain", 32'(addrs), 32'd0);
    chk("rv_drain", 32'(resultValid), 32'd0);
    tick();
    chk("rv_done", 32'(resultValid), 32'd1);
    chk("result", 32'(result), 32'(exp));
    chk("busy_done", 32'(busy), 32'd1);
    tick();
    chk("rv_pulse_end", 32'(resultValid), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("result_hold", 32'(result), 32'(exp));
  endtask

  initial begin
    coef[0] = 12'h008; coef[1] = 12'hFE7; coef[2] = 12'hFAC;
    coef[3] = 12'h0EB; coef[4] = 12'h37A;

    vecs[0] = '{12'h400, 1'b0, 12'h004, 12'h004};
    vecs[1] = '{12'h000, 1'b0, 12'hFF3, 12'hFF4};
    vecs[2] = '{12'h800, 1'b0, 12'hFCE, 12'hFCE};
    vecs[3] = '{12'h800, 1'b0, 12'h086, 12'h087};
    vecs[4] = '{12'h800, 1'b1, 12'h222, 12'h222};
    vecs[5] = '{12'h800, 1'b0, 12'hF7A, 12'hF7A};
    vecs[6] = '{12'h800, 1'b0, 12'hC00, 12'hC00};

    reset       = 1'b1;
    sampleValid = 1'b0;
    sampleIn    = 12'h000;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_addrs", 32'(addrs), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_rv", 32'(resultValid), 32'd0);
    tick();

    for (int v = 0; v < 7; v++) begin
`ifdef FIR_ROUND_EN
      run_sample(vecs[v].sample, vecs[v].pulse, vecs[v].exp_round);
`else
      run_sample(vecs[v].sample, vecs[v].pulse, vecs[v].exp_trunc);
`endif
    end

    // Reset during FETCH aborts the operation and wipes the delay line.
    sampleValid = 1'b1;
    sampleIn    = 12'h400;
    tick();
    sampleValid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("abort_read", 32'(read), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rv", 32'(resultValid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_addrs", 32'(addrs), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort_no_rv", 32'(resultValid), 32'd0);
    end
    run_sample(12'h000, 1'b0, 12'h000);
    run_sample(12'h400, 1'b0, 12'h004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
